// File: rtl/genaxis_pkg.sv
// Shared types and descriptor layout for the genaxis descriptor path.
// Descriptor = {channel, pause[31:0], length[15:0]}, channel width set by the user.
package genaxis_pkg;

  typedef enum logic [1:0] {StIdle, StPause, StIssue, StWaitDone} state_e;

  localparam int unsigned LEN_LSB   = 0;
  localparam int unsigned PAUSE_LSB = 16;
  localparam int unsigned CHAN_LSB  = 48;

  function automatic int unsigned desc_w(input int unsigned id_width);
    return CHAN_LSB + id_width;
  endfunction

  // Fixed-width low part of a descriptor; the channel sits above it.
  typedef struct packed {
    logic [31:0] pause;
    logic [15:0] length;
  } desc_timing_t;

endpackage

// File: rtl/genaxis_rr_arbiter.sv
// Combinational round-robin arbiter: first requester searching upward from ptr+1.
module genaxis_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    int unsigned c;
    logic [IDX_W-1:0] ci;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      c  = (int'(ptr) + i) % N;
      ci = IDX_W'(c);
      if (!found && req[ci]) begin
        found     = 1'b1;
        idx       = ci;
        grant[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/genaxis_descriptor_scheduler.sv
// Grants one descriptor at a time round-robin, waits its pause, issues a command
// to the packet engine and holds the next grant until the packet is done.
module genaxis_descriptor_scheduler
  import genaxis_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned ID_WIDTH = 10,
  localparam int unsigned DESC_W  = desc_w(ID_WIDTH),
  localparam int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable_i,
  input  logic [NUM_SRC*DESC_W-1:0] desc_data_i,
  input  logic [NUM_SRC-1:0]        desc_valid_i,
  output logic [NUM_SRC-1:0]        desc_ready_o,
  output logic [15:0]               cmd_length_o,
  output logic [ID_WIDTH-1:0]       cmd_channel_o,
  output logic [SRC_W-1:0]          cmd_src_o,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  input  logic                      pkt_done_i,
  output logic                      busy_o,
  output logic [31:0]               pkt_issued_o,
  output logic [31:0]               pkt_dropped_o,
  output logic                      err_done_o
);

  state_e              state_q;
  logic [SRC_W-1:0]    ptr_q;
  logic [31:0]         pause_cnt_q;
  logic [NUM_SRC-1:0]  win_grant;
  logic [SRC_W-1:0]    win_idx;
  logic                win_found;
  logic [DESC_W-1:0]   win_desc;
  desc_timing_t        win_timing;
  logic                desc_hs;

  genaxis_rr_arbiter #(
    .N (NUM_SRC)
  ) u_arb (
    .req   (desc_valid_i),
    .ptr   (ptr_q),
    .grant (win_grant),
    .idx   (win_idx),
    .found (win_found)
  );

  assign win_desc   = desc_data_i[DESC_W*int'(win_idx) +: DESC_W];
  assign win_timing = desc_timing_t'(win_desc[CHAN_LSB-1:0]);

  // Ready is masked during reset so no grant is advertised before the FSM runs.
  assign desc_ready_o = (state_q == StIdle && enable_i && win_found && !reset) ? win_grant : '0;
  assign desc_hs      = |desc_ready_o;
  assign busy_o       = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ptr_q         <= SRC_W'(NUM_SRC - 1);
      pause_cnt_q   <= '0;
      cmd_length_o  <= '0;
      cmd_channel_o <= '0;
      cmd_src_o     <= '0;
      cmd_valid_o   <= 1'b0;
      pkt_issued_o  <= '0;
      pkt_dropped_o <= '0;
      err_done_o    <= 1'b0;
    end else begin
      if (pkt_done_i && state_q != StWaitDone) err_done_o <= 1'b1;
      case (state_q)
        StIdle: begin
          if (desc_hs) begin
            cmd_length_o  <= win_timing.length;
            cmd_channel_o <= win_desc[CHAN_LSB +: ID_WIDTH];
            cmd_src_o     <= win_idx;
            ptr_q         <= win_idx;
            if (win_timing.pause == '0) begin
              if (win_timing.length == '0) begin
                pkt_dropped_o <= pkt_dropped_o + 32'd1;
              end else begin
                cmd_valid_o <= 1'b1;
                state_q     <= StIssue;
              end
            end else begin
              pause_cnt_q <= win_timing.pause - 32'd1;
              state_q     <= StPause;
            end
          end
        end
        StPause: begin
          if (pause_cnt_q == '0) begin
            if (cmd_length_o == '0) begin
              pkt_dropped_o <= pkt_dropped_o + 32'd1;
              state_q       <= StIdle;
            end else begin
              cmd_valid_o <= 1'b1;
              state_q     <= StIssue;
            end
          end else begin
            pause_cnt_q <= pause_cnt_q - 32'd1;
          end
        end
        StIssue: begin
          if (cmd_ready_i) begin
            cmd_valid_o  <= 1'b0;
            pkt_issued_o <= pkt_issued_o + 32'd1;
            state_q      <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (pkt_done_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_genaxis_descriptor_scheduler.sv
// Directed bench for genaxis_descriptor_scheduler with a small handshake monitor.
module tb_genaxis_descriptor_scheduler;

  localparam int NS = 4;
  localparam int IW = 10;
  localparam int DW = 48 + IW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable_i = 1'b0;
  logic [NS*DW-1:0]  desc_data_i = '0;
  logic [NS-1:0]     desc_valid_i = '0;
  logic [NS-1:0]     desc_ready_o;
  logic [15:0]       cmd_length_o;
  logic [IW-1:0]     cmd_channel_o;
  logic [1:0]        cmd_src_o;
  logic              cmd_valid_o;
  logic              cmd_ready_i = 1'b1;
  logic              pkt_done_i = 1'b0;
  logic              busy_o;
  logic [31:0]       pkt_issued_o;
  logic [31:0]       pkt_dropped_o;
  logic              err_done_o;

  genaxis_descriptor_scheduler #(
    .NUM_SRC  (NS),
    .ID_WIDTH (IW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_i      (enable_i),
    .desc_data_i   (desc_data_i),
    .desc_valid_i  (desc_valid_i),
    .desc_ready_o  (desc_ready_o),
    .cmd_length_o  (cmd_length_o),
    .cmd_channel_o (cmd_channel_o),
    .cmd_src_o     (cmd_src_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_ready_i   (cmd_ready_i),
    .pkt_done_i    (pkt_done_i),
    .busy_o        (busy_o),
    .pkt_issued_o  (pkt_issued_o),
    .pkt_dropped_o (pkt_dropped_o),
    .err_done_o    (err_done_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_cyc_q[$];
  int hs_src_q[$];
  int cmd_cyc_q[$];
  int cmd_len_q[$];
  int cmd_src_q[$];
  logic [NS-1:0] oneshot = '1;
  logic          auto_done = 1'b1;
  logic [NS-1:0] dhs;
  logic          chs;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Records handshakes, auto-completes packets, retires one-shot descriptors.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      dhs = desc_ready_o & desc_valid_i;
      chs = cmd_valid_o & cmd_ready_i;
      for (int k = 0; k < NS; k++) begin
        if (dhs[k]) begin
          hs_cyc_q.push_back(cyc);
          hs_src_q.push_back(k);
        end
      end
      if (chs) begin
        cmd_cyc_q.push_back(cyc);
        cmd_len_q.push_back(int'(cmd_length_o));
        cmd_src_q.push_back(int'(cmd_src_o));
      end
      #1;
      pkt_done_i   = auto_done & chs;
      desc_valid_i = desc_valid_i & ~(dhs & oneshot);
    end
  end

  task automatic set_desc(input int k, input logic [IW-1:0] ch, input logic [31:0] pause,
                          input logic [15:0] len);
    desc_data_i[k*DW +: DW] = {ch, pause, len};
  endtask

  task automatic clear_q();
    hs_cyc_q.delete();
    hs_src_q.delete();
    cmd_cyc_q.delete();
    cmd_len_q.delete();
    cmd_src_q.delete();
  endtask

  task automatic wait_hs(input string tag, input int n);
    int t = 0;
    while (hs_src_q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, 64'(hs_src_q.size() >= n), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy_o && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, busy_o, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    desc_valid_i = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int exp_order[9];
    int ok;
    exp_order = '{0, 1, 2, 3, 0, 1, 3, 0, 1};

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_valid", cmd_valid_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_issued", pkt_issued_o, 32'd0);
    check_eq("rst_dropped", pkt_dropped_o, 32'd0);
    check_eq("rst_err", err_done_o, 1'b0);
    check_eq("rst_len", cmd_length_o, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    enable_i = 1'b1;

    // Single source, pause 0, back-to-back
    clear_q();
    oneshot = '1;
    oneshot[0] = 1'b0;
    set_desc(0, 10'h015, 32'd0, 16'd64);
    desc_valid_i[0] = 1'b1;
    wait_hs("t1_hs", 2);
    desc_valid_i[0] = 1'b0;
    wait_idle("t1_idle");
    check_eq("t1_cmd_latency", 64'(cmd_cyc_q[0] - hs_cyc_q[0]), 64'd1);
    check_eq("t1_grant_gap", 64'(hs_cyc_q[1] - hs_cyc_q[0]), 64'd3);
    check_eq("t1_len", 64'(cmd_len_q[0]), 64'd64);
    check_eq("t1_chan", cmd_channel_o, 10'h015);
    check_eq("t1_issued", pkt_issued_o, 32'd2);
    oneshot = '1;

    // Pause 5 then pause 1
    clear_q();
    set_desc(0, 10'h001, 32'd5, 16'd32);
    desc_valid_i[0] = 1'b1;
    wait_hs("t2a_hs", 1);
    wait_idle("t2a_idle");
    check_eq("t2_pause5", 64'(cmd_cyc_q[0] - hs_cyc_q[0]), 64'd6);
    clear_q();
    set_desc(0, 10'h001, 32'd1, 16'd32);
    desc_valid_i[0] = 1'b1;
    wait_hs("t2b_hs", 1);
    wait_idle("t2b_idle");
    check_eq("t2_pause1", 64'(cmd_cyc_q[0] - hs_cyc_q[0]), 64'd2);
    check_eq("t2_issued", pkt_issued_o, 32'd4);

    // Round robin, all valid, then source 2 drops out
    do_reset();
    clear_q();
    oneshot = '0;
    for (int k = 0; k < NS; k++) set_desc(k, 10'(k), 32'd0, 16'(16 * (k + 1)));
    desc_valid_i = '1;
    wait_hs("t3a_hs", 6);
    desc_valid_i[2] = 1'b0;
    wait_hs("t3b_hs", 9);
    desc_valid_i = '0;
    wait_idle("t3_idle");
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("t3_order%0d", i), 64'(hs_src_q[i]), 64'(exp_order[i]));
      check_eq($sformatf("t3_len%0d", i), 64'(cmd_len_q[i]), 64'(16 * (exp_order[i] + 1)));
    end
    check_eq("t3_issued", pkt_issued_o, 32'd9);
    oneshot = '1;

    // Zero length dropped, then length 100
    clear_q();
    set_desc(1, 10'h0AA, 32'd0, 16'd0);
    desc_valid_i[1] = 1'b1;
    wait_hs("t4a_hs", 1);
    check_eq("t4_dropped", pkt_dropped_o, 32'd1);
    set_desc(1, 10'h0AA, 32'd0, 16'd100);
    desc_valid_i[1] = 1'b1;
    wait_hs("t4b_hs", 2);
    wait_idle("t4_idle");
    check_eq("t4_cmd_count", 64'(cmd_len_q.size()), 64'd1);
    check_eq("t4_len", 64'(cmd_len_q[0]), 64'd100);
    check_eq("t4_issued", pkt_issued_o, 32'd10);

    // Backpressure with a spurious done during ISSUE
    clear_q();
    cmd_ready_i = 1'b0;
    set_desc(3, 10'h3AB, 32'd0, 16'd500);
    desc_valid_i[3] = 1'b1;
    wait_hs("t5_hs", 1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid_o && cmd_length_o == 16'd500 && cmd_channel_o == 10'h3AB && cmd_src_o == 2'd3)
        ok++;
      if (i == 5) pkt_done_i = 1'b1;
      @(negedge clk);
    end
    check_eq("t5_hold", 64'(ok), 64'd20);
    check_eq("t5_err", err_done_o, 1'b1);
    check_eq("t5_still_valid", cmd_valid_o, 1'b1);
    cmd_ready_i = 1'b1;
    wait_idle("t5_idle");
    check_eq("t5_issued", pkt_issued_o, 32'd11);
    check_eq("t5_src", 64'(cmd_src_q[0]), 64'd3);

    // Reset during a long pause
    clear_q();
    set_desc(2, 10'h022, 32'd1000, 16'd8);
    desc_valid_i[2] = 1'b1;
    wait_hs("t6_hs", 1);
    repeat (10) @(negedge clk);
    check_eq("t6_pause_busy", busy_o, 1'b1);
    check_eq("t6_pause_novalid", cmd_valid_o, 1'b0);
    reset = 1'b1;
    desc_valid_i = 4'b0101;
    @(negedge clk);
    check_eq("t6_rst_ready", desc_ready_o, 4'b0000);
    check_eq("t6_rst_busy", busy_o, 1'b0);
    check_eq("t6_rst_issued", pkt_issued_o, 32'd0);
    check_eq("t6_rst_err", err_done_o, 1'b0);
    check_eq("t6_rst_len", cmd_length_o, 16'd0);
    check_eq("t6_rst_chan", cmd_channel_o, 10'd0);
    check_eq("t6_rst_src", cmd_src_o, 2'd0);
    clear_q();
    set_desc(0, 10'h100, 32'd3, 16'd12);
    set_desc(2, 10'h022, 32'd0, 16'd8);
    reset = 1'b0;
    wait_hs("t6b_hs", 2);
    wait_idle("t6_idle");
    check_eq("t6_first_src", 64'(hs_src_q[0]), 64'd0);
    check_eq("t6_second_src", 64'(hs_src_q[1]), 64'd2);
    check_eq("t6_fresh_pause", 64'(cmd_cyc_q[0] - hs_cyc_q[0]), 64'd4);
    check_eq("t6_issued", pkt_issued_o, 32'd2);
    check_eq("t6_dropped", pkt_dropped_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
